// File: rtl/hs_reg_slice.sv
// hs_reg_slice: parametrised valid/ready register slice with bypass, forward, skid and full modes
module hs_reg_slice #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter int MODE = 3,
  localparam int OW = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [WIDTH-1:0] s_data,
  output logic [OW-1:0]    occupancy
);
  if (MODE == 0) begin : g_bypass
    assign s_valid = rst && m_valid;
    assign s_data = rst ? m_data : '0;
    assign m_ready = rst && s_ready;
    assign occupancy = '0;
  end else begin : g_chain
    logic v [DEPTH+1];
    logic r [DEPTH+1];
    logic [WIDTH-1:0] d [DEPTH+1];
    logic [OW-1:0] occ;
    assign v[0] = m_valid;
    assign d[0] = m_data;
    assign r[DEPTH] = s_ready;
    // outputs are gated so nothing is offered or accepted while rst is low
    assign m_ready = rst && r[0];
    assign s_valid = rst && v[DEPTH];
    assign s_data = rst ? d[DEPTH] : '0;
    assign occupancy = occ;
    always_ff @(posedge clk)
      if (!rst) occ <= '0;
      else occ <= occ + OW'(m_valid && m_ready) - OW'(s_valid && s_ready);
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (MODE == 1) begin : g_fwd
        logic ov;
        logic [WIDTH-1:0] od;
        assign r[k] = r[k+1] || !ov;
        assign v[k+1] = ov;
        assign d[k+1] = od;
        always_ff @(posedge clk)
          if (!rst) begin
            ov <= 1'b0;
            od <= '0;
          end else if (r[k]) begin
            ov <= v[k];
            od <= v[k] ? d[k] : od;
          end
      end else if (MODE == 2) begin : g_skid
        logic skid_full, rdy;
        logic [WIDTH-1:0] skid_data;
        assign r[k] = rdy;
        assign v[k+1] = skid_full || v[k];
        assign d[k+1] = skid_full ? skid_data : d[k];
        always_ff @(posedge clk)
          if (!rst) begin
            skid_full <= 1'b0;
            rdy <= 1'b1;
            skid_data <= '0;
          end else if (v[k] && rdy && !r[k+1]) begin
            skid_full <= 1'b1;
            rdy <= 1'b0;
            skid_data <= d[k];
          end else if (skid_full && r[k+1]) begin
            skid_full <= 1'b0;
            rdy <= 1'b1;
          end
      end else begin : g_full
        logic [1:0] cnt, cnt_n;
        logic rdy, push, pop;
        logic [WIDTH-1:0] e0, e1;
        assign push = v[k] && rdy;
        assign pop = (cnt != 2'd0) && r[k+1];
        assign cnt_n = cnt + {1'b0, push} - {1'b0, pop};
        assign r[k] = rdy;
        assign v[k+1] = cnt != 2'd0;
        assign d[k+1] = e0;
        // e0 is the head entry; e1 only matters once two words are held
        always_ff @(posedge clk)
          if (!rst) begin
            cnt <= 2'd0;
            rdy <= 1'b1;
            e0 <= '0;
            e1 <= '0;
          end else begin
            cnt <= cnt_n;
            rdy <= cnt_n != 2'd2;
            e0 <= (push && (cnt == 2'd0 || (pop && cnt == 2'd1))) ? d[k] : pop ? e1 : e0;
            e1 <= push ? d[k] : e1;
          end
      end
    end
  end
endmodule

// File: tb/tb_hs_reg_slice.sv
// tb_hs_reg_slice: scoreboard bench over several MODE/DEPTH configurations of hs_reg_slice
module tb_hs_reg_slice;
  localparam int N = 11;
  localparam int MODES [N] = '{3, 1, 2, 3, 2, 0, 1, 1, 2, 3, 3};
  localparam int DEPTHS [N] = '{2, 3, 3, 3, 1, 1, 1, 4, 2, 4, 1};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] mv, sr, mr, sv;
  logic [7:0] md [N];
  logic [7:0] sd [N];
  logic [3:0] occ [N];
  int checks = 0;
  int fails = 0;
  bit done = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int D = DEPTHS[i];
    logic [$clog2(2*D+1)-1:0] oc;
    logic [7:0] q [$];
    logic rst_q = 1'b0;
    hs_reg_slice #(.WIDTH(8), .DEPTH(D), .MODE(MODES[i])) dut (
      .clk(clk), .rst(rst), .m_valid(mv[i]), .m_ready(mr[i]), .m_data(md[i]),
      .s_valid(sv[i]), .s_ready(sr[i]), .s_data(sd[i]), .occupancy(oc));
    assign occ[i] = 4'(oc);
    initial forever begin
      @(posedge clk);
      rst_q = rst;
    end
    // monitor: accepted words go into the queue, delivered words must come out in order
    initial begin
      logic hold;
      logic [7:0] hold_d, exp_d;
      hold = 1'b0;
      hold_d = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          q.delete();
          hold = 1'b0;
          chk("m_ready_in_reset", i, mr[i], 0);
          chk("s_valid_in_reset", i, sv[i], 0);
        end else begin
          if (!rst_q) chk("occ_after_reset", i, occ[i], 0);
          if (hold && rst_q) begin
            chk("s_valid_hold", i, sv[i], 1);
            chk("s_data_hold", i, sd[i], hold_d);
          end
          chk("occupancy", i, occ[i], q.size());
          if (mv[i] && mr[i]) q.push_back(md[i]);
          if (sv[i] && sr[i]) begin
            if (q.size() == 0) chk("spurious_output", i, q.size(), 1);
            else begin
              exp_d = q.pop_front();
              chk("order", i, sd[i], exp_d);
            end
          end
          hold = sv[i] && !sr[i];
          hold_d = sd[i];
          if (done) chk("drained", i, q.size(), 0);
        end
      end
    end
  end
  task automatic stream(input int i, input int lat, input int eocc);
    for (int k = 0; k < 64 + lat; k++) begin
      step();
      mv[i] = k < 64;
      md[i] = 8'(k);
      @(negedge clk);
      if (k < 64) chk("stream_m_ready", i, mr[i], 1);
      if (k >= lat) begin
        chk("stream_s_valid", i, sv[i], 1);
        chk("stream_s_data", i, sd[i], k - lat);
      end
      if (k >= lat && k < 64) chk("stream_occ", i, occ[i], eocc);
    end
    step();
    mv[i] = 1'b0;
  endtask
  initial begin
    int acc, thr;
    logic seen;
    logic [N-1:0] acc_v;
    mv = '0;
    sr = '1;
    for (int j = 0; j < N; j++) md[j] = '0;
    mv[0] = 1'b1;
    md[0] = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", 0, sv[0], 0);
    chk("rst_s_data", 0, sd[0], 0);
    chk("rst_m_ready", 0, mr[0], 0);
    chk("rst_occ", 0, occ[0], 0);
    step();
    rst = 1'b1;
    mv[0] = 1'b0;
    step();
    @(negedge clk);
    chk("m_ready_after_reset", 0, mr[0], 1);
    stream(1, 3, 3);
    stream(2, 0, 0);
    stream(3, 3, 3);
    // full stall on MODE 3 DEPTH 2: capacity is four words
    step();
    sr[0] = 1'b0;
    mv[0] = 1'b1;
    md[0] = 8'h10;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!mr[0]) break;
      acc++;
      step();
      md[0] = 8'(8'h10 + acc);
    end
    chk("stall_accepted", 0, acc, 4);
    chk("stall_occ", 0, occ[0], 4);
    chk("stall_s_data", 0, sd[0], 8'h10);
    step();
    mv[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_hold_data", 0, sd[0], 8'h10);
      chk("stall_hold_m_ready", 0, mr[0], 0);
      step();
    end
    sr[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("drain_s_valid", 0, sv[0], 1);
      chk("drain_s_data", 0, sd[0], 8'h10 + n);
      step();
    end
    @(negedge clk);
    chk("drain_empty", 0, sv[0], 0);
    // skid behaviour on MODE 2 DEPTH 1
    step();
    mv[4] = 1'b1;
    md[4] = 8'h11;
    @(negedge clk);
    chk("skid_pass_valid", 4, sv[4], 1);
    chk("skid_pass_data", 4, sd[4], 8'h11);
    chk("skid_pass_m_ready", 4, mr[4], 1);
    step();
    sr[4] = 1'b0;
    md[4] = 8'h22;
    @(negedge clk);
    chk("skid_load_m_ready", 4, mr[4], 1);
    chk("skid_load_data", 4, sd[4], 8'h22);
    step();
    mv[4] = 1'b0;
    @(negedge clk);
    chk("skid_full_m_ready", 4, mr[4], 0);
    chk("skid_full_data", 4, sd[4], 8'h22);
    chk("skid_full_occ", 4, occ[4], 1);
    step();
    sr[4] = 1'b1;
    @(negedge clk);
    chk("skid_release_valid", 4, sv[4], 1);
    chk("skid_release_data", 4, sd[4], 8'h22);
    step();
    @(negedge clk);
    chk("skid_m_ready_back", 4, mr[4], 1);
    chk("skid_empty_valid", 4, sv[4], 0);
    chk("skid_empty_occ", 4, occ[4], 0);
    // mid-stream reset with three words held
    step();
    sr[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      mv[0] = 1'b1;
      md[0] = 8'(8'h31 + n);
      @(negedge clk);
      chk("mid_push_m_ready", 0, mr[0], 1);
      step();
    end
    mv[0] = 1'b0;
    @(negedge clk);
    chk("mid_occ", 0, occ[0], 3);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    sr[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_occ", 0, occ[0], 0);
    chk("mid_rst_s_valid", 0, sv[0], 0);
    step();
    mv[0] = 1'b1;
    md[0] = 8'h5A;
    @(negedge clk);
    chk("mid_m_ready", 0, mr[0], 1);
    step();
    mv[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sv[0]) begin
        chk("mid_first_word", 0, sd[0], 8'h5A);
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("mid_word_seen", 0, seen, 1);
    // random traffic, upstream holds a word until it is accepted
    for (int c = 0; c < 10000; c++) begin
      thr = 2 + 2 * (c / 2500);
      @(negedge clk);
      acc_v = mv & mr;
      step();
      for (int j = 0; j < N; j++) begin
        if (acc_v[j] || !mv[j]) begin
          mv[j] = $urandom_range(0, 3) != 0;
          md[j] = 8'($urandom);
        end
        sr[j] = $urandom_range(0, 9) < thr;
      end
    end
    step();
    mv = '0;
    sr = '1;
    repeat (20) step();
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
